// File: rtl/pipeline_param.sv
// pipeline_param: 3-stage (ID, EX, WB) integer pipeline with parametric data width and register count.
// Build with PIPELINE_PARAM_FWD_EN defined to add EX/WB-to-ID operand forwarding.
module pipeline_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       InstrIn,
   input  logic              InstrValid,
   output logic [DATA_W-1:0] Out,
   output logic              OutValid
);

   localparam int NREG = 1 << ADDR_W;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_NOT,
      ALU_OR,
      ALU_AND,
      ALU_SLT
   } alu_op_e;

   logic [5:0]        opcode;
   logic [ADDR_W-1:0] rd;
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [DATA_W-1:0] imm;
   logic              id_legal;
   logic              id_use_imm;
   alu_op_e           id_op;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;
   logic [DATA_W-1:0] alu_y;

   logic [DATA_W-1:0] rf_q [NREG];
   logic [DATA_W-1:0] rf_d [NREG];

   logic              ex_valid_q, ex_valid_d;
   alu_op_e           ex_op_q, ex_op_d;
   logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
   logic [DATA_W-1:0] ex_a_q, ex_a_d;
   logic [DATA_W-1:0] ex_b_q, ex_b_d;

   logic              wb_valid_q, wb_valid_d;
   logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   // Register fields narrower than 5 bits leave instruction bits unread.
   logic unused_instr_bits;
   assign unused_instr_bits = ^InstrIn;

   always_comb begin
      opcode     = InstrIn[31:26];
      rd         = InstrIn[21 +: ADDR_W];
      rs         = InstrIn[16 +: ADDR_W];
      rt         = InstrIn[11 +: ADDR_W];
      imm        = DATA_W'(InstrIn[15:0]);
      id_legal   = 1'b1;
      id_use_imm = 1'b1;
      id_op      = ALU_ADD;
      case (opcode)
         6'b010101: begin id_op = ALU_ADD; id_use_imm = 1'b0; end
         6'b010110: begin id_op = ALU_SUB; id_use_imm = 1'b0; end
         6'b010000: begin id_op = ALU_NOT; id_use_imm = 1'b0; end
         6'b011101: id_op = ALU_ADD;
         6'b011011: id_op = ALU_OR;
         6'b011100: id_op = ALU_AND;
         6'b011000: id_op = ALU_NOT;
         6'b011111: id_op = ALU_SLT;
         default:   id_legal = 1'b0;
      endcase
   end

   always_comb begin
      rs_val = rf_q[rs];
      rt_val = rf_q[rt];
`ifdef PIPELINE_PARAM_FWD_EN
      // EX is checked first so the youngest producer wins.
      if (ex_valid_q && (ex_rd_q == rs))      fwd_rs = alu_y;
      else if (wb_valid_q && (wb_rd_q == rs)) fwd_rs = wb_data_q;
      else                                    fwd_rs = rs_val;
      if (ex_valid_q && (ex_rd_q == rt))      fwd_rt = alu_y;
      else if (wb_valid_q && (wb_rd_q == rt)) fwd_rt = wb_data_q;
      else                                    fwd_rt = rt_val;
`else
      fwd_rs = rs_val;
      fwd_rt = rt_val;
`endif
   end

   always_comb begin
      ex_valid_d = InstrValid && id_legal;
      ex_op_d    = id_op;
      ex_rd_d    = rd;
      ex_a_d     = fwd_rs;
      ex_b_d     = id_use_imm ? imm : fwd_rt;
   end

   always_comb begin
      alu_y = '0;
      case (ex_op_q)
         ALU_ADD: alu_y = ex_a_q + ex_b_q;
         ALU_SUB: alu_y = ex_a_q - ex_b_q;
         ALU_NOT: alu_y = ~ex_a_q;
         ALU_OR:  alu_y = ex_a_q | ex_b_q;
         ALU_AND: alu_y = ex_a_q & ex_b_q;
         ALU_SLT: alu_y = DATA_W'($signed(ex_a_q) < $signed(ex_b_q));
         default: alu_y = '0;
      endcase
   end

   // Result data is held through bubbles so Out keeps the last real value.
   always_comb begin
      wb_valid_d = ex_valid_q;
      wb_rd_d    = ex_rd_q;
      wb_data_d  = ex_valid_q ? alu_y : wb_data_q;
   end

   always_comb begin
      rf_d = rf_q;
      if (wb_valid_q) rf_d[wb_rd_q] = wb_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_op_q    <= ALU_ADD;
         ex_rd_q    <= '0;
         ex_a_q     <= '0;
         ex_b_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_op_q    <= ex_op_d;
         ex_rd_q    <= ex_rd_d;
         ex_a_q     <= ex_a_d;
         ex_b_q     <= ex_b_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         rf_q       <= rf_d;
      end
   end

   assign Out      = wb_data_q;
   assign OutValid = wb_valid_q;

endmodule

// File: tb/tb_pipeline_param.sv
// Directed bench for pipeline_param: a 32-bit/32-register instance and a 16-bit/8-register instance.
module tb_pipeline_param;

   localparam logic [5:0] OP_ADD  = 6'b010101;
   localparam logic [5:0] OP_SUB  = 6'b010110;
   localparam logic [5:0] OP_NOT  = 6'b010000;
   localparam logic [5:0] OP_ADDI = 6'b011101;
   localparam logic [5:0] OP_ORI  = 6'b011011;
   localparam logic [5:0] OP_ANDI = 6'b011100;
   localparam logic [5:0] OP_NOTI = 6'b011000;
   localparam logic [5:0] OP_SLTI = 6'b011111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr_a = '0;
   logic        valid_a = 1'b0;
   logic [31:0] out_a;
   logic        outv_a;
   logic [31:0] instr_b = '0;
   logic        valid_b = 1'b0;
   logic [15:0] out_b;
   logic        outv_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipeline_param #(.DATA_W(32), .ADDR_W(5)) dut_a (
      .clk(clk), .rst(rst), .InstrIn(instr_a), .InstrValid(valid_a),
      .Out(out_a), .OutValid(outv_a)
   );

   pipeline_param #(.DATA_W(16), .ADDR_W(3)) dut_b (
      .clk(clk), .rst(rst), .InstrIn(instr_b), .InstrValid(valid_b),
      .Out(out_b), .OutValid(outv_b)
   );

   function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] d,
                                         input logic [4:0] s, input logic [4:0] t);
      return {op, d, s, t, 11'b0};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] d,
                                         input logic [4:0] s, input logic [15:0] imm);
      return {op, d, s, imm};
   endfunction

   // sel=0 drives instance A, sel=1 drives instance B; the other one gets a bubble.
   task automatic tick(input logic r, input logic sel, input logic v, input logic [31:0] ins);
      @(negedge clk);
      rst = r;
      if (!sel) begin
         valid_a = v; instr_a = ins; valid_b = 1'b0; instr_b = '0;
      end else begin
         valid_b = v; instr_b = ins; valid_a = 1'b0; instr_a = '0;
      end
   endtask

   task automatic bub();
      tick(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic exp_v, input logic [31:0] exp_out);
      chk({tag, "_valid"}, {31'b0, outv_a}, {31'b0, exp_v});
      chk({tag, "_out"}, out_a, exp_out);
   endtask

   task automatic chk_b(input string tag, input logic exp_v, input logic [15:0] exp_out);
      chk({tag, "_valid"}, {31'b0, outv_b}, {31'b0, exp_v});
      chk({tag, "_out"}, {16'h0, out_b}, {16'h0, exp_out});
   endtask

   initial begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      chk_a("rst_a", 1'b0, 32'h0);
      chk_b("rst_b", 1'b0, 16'h0);
      tick(1'b0, 1'b0, 1'b1, rtype(OP_ADD, 5'd3, 5'd1, 5'd2));
      bub();
      bub();
      chk_a("add_after_rst", 1'b1, 32'h0);

`ifdef PIPELINE_PARAM_FWD_EN
      tick(1'b0, 1'b0, 1'b1, itype(OP_ADDI, 5'd1, 5'd1, 16'h000A));
      tick(1'b0, 1'b0, 1'b1, itype(OP_ORI,  5'd2, 5'd2, 16'h0002));
      tick(1'b0, 1'b0, 1'b1, rtype(OP_ADD,  5'd3, 5'd1, 5'd2));
      chk_a("chain_addi", 1'b1, 32'hA);
      tick(1'b0, 1'b0, 1'b1, rtype(OP_SUB,  5'd4, 5'd1, 5'd2));
      chk_a("chain_ori", 1'b1, 32'h2);
      bub();
      chk_a("chain_add_fwd", 1'b1, 32'hC);
      bub();
      chk_a("chain_sub_fwd", 1'b1, 32'h8);
`else
      tick(1'b0, 1'b0, 1'b1, itype(OP_ADDI, 5'd1, 5'd1, 16'h000A));
      bub(); bub();
      chk_a("chain_addi", 1'b1, 32'hA);
      tick(1'b0, 1'b0, 1'b1, itype(OP_ORI,  5'd2, 5'd2, 16'h0002));
      bub(); bub();
      chk_a("chain_ori", 1'b1, 32'h2);
      tick(1'b0, 1'b0, 1'b1, rtype(OP_ADD,  5'd3, 5'd1, 5'd2));
      bub(); bub();
      chk_a("chain_add", 1'b1, 32'hC);
      tick(1'b0, 1'b0, 1'b1, rtype(OP_SUB,  5'd4, 5'd1, 5'd2));
      bub(); bub();
      chk_a("chain_sub", 1'b1, 32'h8);
`endif

      // r1=A r2=2 r3=C r4=8, others 0
      tick(1'b0, 1'b0, 1'b1, itype(OP_NOTI, 5'd7,  5'd3, 16'h1234));
      tick(1'b0, 1'b0, 1'b1, itype(OP_SLTI, 5'd10, 5'd6, 16'hFFF8));
      tick(1'b0, 1'b0, 1'b1, itype(OP_ANDI, 5'd11, 5'd5, 16'hFFFF));
      chk_a("noti", 1'b1, 32'hFFFF_FFF3);
      tick(1'b0, 1'b0, 1'b1, rtype(OP_NOT,  5'd12, 5'd4, 5'd0));
      chk_a("slti_zext", 1'b1, 32'h1);
      tick(1'b0, 1'b0, 1'b1, rtype(OP_SUB,  5'd13, 5'd0, 5'd1));
      chk_a("andi", 1'b1, 32'h0);
      tick(1'b0, 1'b0, 1'b1, itype(OP_ORI,  5'd14, 5'd3, 16'h0F00));
      chk_a("not", 1'b1, 32'hFFFF_FFF7);
      bub();
      chk_a("sub_wrap", 1'b1, 32'hFFFF_FFF6);
      bub();
      chk_a("ori", 1'b1, 32'h0000_0F0C);

      tick(1'b0, 1'b0, 1'b1, itype(OP_ADDI, 5'd16, 5'd7, 16'h000D));
      tick(1'b0, 1'b0, 1'b1, itype(OP_SLTI, 5'd17, 5'd1, 16'h0005));
      tick(1'b0, 1'b0, 1'b1, itype(OP_SLTI, 5'd15, 5'd7, 16'h0001));
      chk_a("addi_wrap", 1'b1, 32'h0);
      bub();
      chk_a("slti_false", 1'b1, 32'h0);
      bub();
      chk_a("slti_neg", 1'b1, 32'h1);

      tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      tick(1'b0, 1'b0, 1'b0, itype(OP_ADDI, 5'd1, 5'd1, 16'h0005));
      tick(1'b0, 1'b0, 1'b1, {6'b000000, 5'd2, 5'd2, 16'h0005});
      chk_a("nop_ff", 1'b0, 32'h1);
      tick(1'b0, 1'b0, 1'b1, rtype(OP_ADD, 5'd8, 5'd1, 5'd2));
      chk_a("bubble", 1'b0, 32'h1);
      bub();
      chk_a("nop_00", 1'b0, 32'h1);
      bub();
      chk_a("add_after_nops", 1'b1, 32'hC);

      tick(1'b0, 1'b0, 1'b1, itype(OP_ADDI, 5'd5, 5'd5, 16'h0007));
      tick(1'b1, 1'b0, 1'b1, itype(OP_ADDI, 5'd6, 5'd0, 16'h0005));
      tick(1'b0, 1'b0, 1'b1, rtype(OP_ADD, 5'd9, 5'd5, 5'd0));
      chk_a("midrst_out", 1'b0, 32'h0);
      bub();
      chk_a("midrst_drop", 1'b0, 32'h0);
      bub();
      chk_a("midrst_add_r9", 1'b1, 32'h0);
      tick(1'b0, 1'b0, 1'b1, rtype(OP_ADD, 5'd18, 5'd1, 5'd2));
      bub(); bub();
      chk_a("midrst_rf_clear", 1'b1, 32'h0);

      tick(1'b0, 1'b1, 1'b1, itype(OP_ADDI, 5'd1, 5'd1, 16'hFFFF));
      tick(1'b0, 1'b1, 1'b1, itype(OP_ADDI, 5'd1, 5'd1, 16'h0001));
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      chk_b("b16_first", 1'b1, 16'hFFFF);
      tick(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef PIPELINE_PARAM_FWD_EN
      chk_b("b16_b2b", 1'b1, 16'h0000);
`else
      chk_b("b16_b2b_stale", 1'b1, 16'h0001);
`endif
      tick(1'b0, 1'b1, 1'b1, itype(OP_ADDI, 5'd2, 5'd2, 16'hFFFF));
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      chk_b("b16_sp_first", 1'b1, 16'hFFFF);
      tick(1'b0, 1'b1, 1'b1, itype(OP_ADDI, 5'd2, 5'd2, 16'h0001));
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      chk_b("b16_sp_wrap", 1'b1, 16'h0000);
      // fields 9/10/11 alias r1/r2/r3 with 3-bit register indices
      tick(1'b0, 1'b1, 1'b1, rtype(OP_ADD, 5'd11, 5'd9, 5'd10));
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef PIPELINE_PARAM_FWD_EN
      chk_b("b16_alias", 1'b1, 16'h0000);
`else
      chk_b("b16_alias", 1'b1, 16'h0001);
`endif
      chk_a("a_idle_during_b", 1'b0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
